// File: rtl/fwd_stage_buf_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fwd_stage_buf_if : input, forward, local and error bundle for        |
// |                    fwd_stage_buf.                                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fwd_stage_buf_if #(
  parameter int PKT_W = 16,
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [PKT_W-1:0] in_packet;
  logic             fwd_valid;
  logic             fwd_ready;
  logic [PKT_W-1:0] fwd_packet;
  logic             loc_valid;
  logic             loc_ready;
  logic [PKT_W-1:0] loc_packet;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_packet, fwd_ready, loc_ready,
    input  in_ready, fwd_valid, fwd_packet, loc_valid, loc_packet,
           err_pulse, err_count
  );

  modport slave (
    input  in_valid, in_packet, fwd_ready, loc_ready,
    output in_ready, fwd_valid, fwd_packet, loc_valid, loc_packet,
           err_pulse, err_count
  );
endinterface
`default_nettype wire

// File: rtl/fwd_stage_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fwd_stage_buf : single-axis forwarding stage with per-output FWFT    |
// |                 FIFOs and saturating drop accounting.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fwd_stage_buf #(
  parameter int PKT_W      = 16,
  parameter int OFF_LSB    = 4,
  parameter int OFF_W      = 4,
  parameter int DIR_POS    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  fwd_stage_buf_if.slave io_bus
);
  localparam int                 c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                 c_OCC_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_OCC_W-1:0] c_FULL    = c_OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   c_ERR_MAX = '1;

  logic [OFF_W-1:0] w_off;
  logic [OFF_W-1:0] w_off_next;
  logic             w_off_neg;
  logic             w_is_zero;
  logic             w_is_fwd;
  logic             w_accept;
  logic             w_drop;
  logic [PKT_W-1:0] w_fwd_pkt;

  // Channel 0 is the forward FIFO, channel 1 the local FIFO.
  logic             w_push  [2];
  logic             w_pop   [2];
  logic             w_ready [2];
  logic             w_full  [2];
  logic             w_valid [2];
  logic [PKT_W-1:0] w_din   [2];
  logic [PKT_W-1:0] w_head  [2];

  logic             r_err_pulse;
  logic [CNT_W-1:0] r_err_count;

  assign w_off     = io_bus.in_packet[OFF_LSB +: OFF_W];
  assign w_off_neg = w_off[OFF_W-1];
  assign w_is_zero = (w_off == '0);
  assign w_is_fwd  = (DIR_POS != 0) ? (!w_off_neg && !w_is_zero) : w_off_neg;
  assign w_off_next = (DIR_POS != 0) ? (w_off - 1'b1) : (w_off + 1'b1);

  always_comb begin
    w_fwd_pkt                    = io_bus.in_packet;
    w_fwd_pkt[OFF_LSB +: OFF_W]  = w_off_next;
  end

  // Acceptance ignores the packet contents and any same-cycle pop.
  assign io_bus.in_ready = !w_full[0] && !w_full[1];
  assign w_accept        = io_bus.in_valid && io_bus.in_ready;
  assign w_drop          = w_accept && !w_is_zero && !w_is_fwd;

  assign w_push[0]  = w_accept && w_is_fwd;
  assign w_push[1]  = w_accept && w_is_zero;
  assign w_din[0]   = w_fwd_pkt;
  assign w_din[1]   = io_bus.in_packet;
  assign w_ready[0] = io_bus.fwd_ready;
  assign w_ready[1] = io_bus.loc_ready;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [PKT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_OCC_W-1:0] r_count;

    always_ff @(posedge clk) begin
      if (w_push[g]) begin
        r_mem[r_wptr] <= w_din[g];
      end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push[g]) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop[g]) begin
          r_rptr <= r_rptr + 1'b1;
        end
        case ({w_push[g], w_pop[g]})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    assign w_valid[g] = (r_count != '0);
    assign w_full[g]  = (r_count == c_FULL);
    assign w_pop[g]   = w_valid[g] && w_ready[g];
    // Head reads as zero while empty so the reset value needs no memory reset.
    assign w_head[g]  = w_valid[g] ? r_mem[r_rptr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_drop;
      if (w_drop && (r_err_count != c_ERR_MAX)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign io_bus.fwd_valid  = w_valid[0];
  assign io_bus.fwd_packet = w_head[0];
  assign io_bus.loc_valid  = w_valid[1];
  assign io_bus.loc_packet = w_head[1];
  assign io_bus.err_pulse  = r_err_pulse;
  assign io_bus.err_count  = r_err_count;
endmodule
`default_nettype wire

// File: tb/tb_fwd_stage_buf.sv
`default_nettype none
// Scoreboard bench for fwd_stage_buf: DIR_POS=1 instance under directed and
// random traffic, plus a DIR_POS=0 instance for the opposite direction.
module tb_fwd_stage_buf;
  localparam int PKT_W   = 16;
  localparam int OFF_LSB = 4;
  localparam int OFF_W   = 4;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwd_stage_buf_if #(.PKT_W(PKT_W), .CNT_W(CNT_W)) bus  ();
  fwd_stage_buf_if #(.PKT_W(PKT_W), .CNT_W(CNT_W)) nbus ();

  fwd_stage_buf #(
    .PKT_W(PKT_W), .OFF_LSB(OFF_LSB), .OFF_W(OFF_W),
    .DIR_POS(1), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

  fwd_stage_buf #(
    .PKT_W(PKT_W), .OFF_LSB(OFF_LSB), .OFF_W(OFF_W),
    .DIR_POS(0), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) u_dut_neg (.clk(clk), .rst_n(rst_n), .io_bus(nbus));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int off_of(input logic [15:0] p);
    logic signed [OFF_W-1:0] f;
    int o;
    f = p[OFF_LSB +: OFF_W];
    o = f;
    return o;
  endfunction

  function automatic logic [15:0] with_off(input logic [15:0] p, input int o);
    logic [15:0] r;
    r = p;
    r[OFF_LSB +: OFF_W] = o[OFF_W-1:0];
    return r;
  endfunction

  function automatic logic [15:0] mk(input int o);
    logic [15:0] r;
    r = 16'($urandom());
    return with_off(r, o);
  endfunction

  logic [15:0] fq[$];
  logic [15:0] lq[$];
  int  exp_cnt   = 0;
  bit  exp_pulse = 1'b0;
  bit  pop_f     = 1'b0;
  bit  pop_l     = 1'b0;
  bit  last_acc  = 1'b0;

  // Monitor: compares DUT outputs with the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      pop_f = 1'b0;
      pop_l = 1'b0;
      check("fwd_valid", bus.fwd_valid, fq.size() != 0);
      if (bus.fwd_valid && fq.size() != 0) begin
        check("fwd_packet", bus.fwd_packet, fq[0]);
        if (bus.fwd_ready) begin
          void'(fq.pop_front());
          pop_f = 1'b1;
        end
      end
      check("loc_valid", bus.loc_valid, lq.size() != 0);
      if (bus.loc_valid && lq.size() != 0) begin
        check("loc_packet", bus.loc_packet, lq[0]);
        if (bus.loc_ready) begin
          void'(lq.pop_front());
          pop_l = 1'b1;
        end
      end
      check("err_pulse", bus.err_pulse, exp_pulse);
      check("err_count", bus.err_count, exp_cnt[CNT_W-1:0]);
    end
  end

  // Predictor: classifies each accepted packet and queues its expected result.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      check("in_ready", bus.in_ready,
            (fq.size() + int'(pop_f) < DEPTH) && (lq.size() + int'(pop_l) < DEPTH));
      last_acc  = bus.in_valid && bus.in_ready;
      exp_pulse = 1'b0;
      if (last_acc) begin
        int o;
        o = off_of(bus.in_packet);
        if (o == 0) lq.push_back(bus.in_packet);
        else if (o > 0) fq.push_back(with_off(bus.in_packet, o - 1));
        else begin
          exp_pulse = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end
      end
    end
  end

  // Ready drivers
  bit rnd_rdy = 1'b0;
  bit fr = 1'b1;
  bit lr = 1'b1;
  initial begin
    bus.fwd_ready = 1'b1;
    bus.loc_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.fwd_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : fr;
      bus.loc_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : lr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] p);
    bus.in_valid  = 1'b1;
    bus.in_packet = p;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (last_acc) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_timeout: packet %h not accepted within 200 cycles", p);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid   = 1'b0;
    bus.in_packet  = '0;
    nbus.in_valid  = 1'b0;
    nbus.in_packet = '0;
    nbus.fwd_ready = 1'b1;
    nbus.loc_ready = 1'b1;

    #2;
    check("rst_in_ready",   bus.in_ready,   1);
    check("rst_fwd_valid",  bus.fwd_valid,  0);
    check("rst_loc_valid",  bus.loc_valid,  0);
    check("rst_fwd_packet", bus.fwd_packet, 0);
    check("rst_loc_packet", bus.loc_packet, 0);
    check("rst_err_pulse",  bus.err_pulse,  0);
    check("rst_err_count",  bus.err_count,  0);
    tick();
    rst_n = 1'b1;

    // Opposite-direction instance.
    tick();
    nbus.in_valid  = 1'b1;
    nbus.in_packet = 16'h00E0;
    tick();
    nbus.in_valid = 1'b0;
    @(negedge clk);
    check("neg_fwd_valid",  nbus.fwd_valid,  1);
    check("neg_fwd_packet", nbus.fwd_packet, 16'h00F0);
    tick();
    nbus.in_valid  = 1'b1;
    nbus.in_packet = 16'h0020;
    tick();
    nbus.in_valid = 1'b0;
    @(negedge clk);
    check("neg_err_pulse", nbus.err_pulse, 1);
    check("neg_err_count", nbus.err_count, 1);
    check("neg_fwd_empty", nbus.fwd_valid, 0);
    tick();
    nbus.in_valid  = 1'b1;
    nbus.in_packet = 16'h0A03;
    tick();
    nbus.in_valid = 1'b0;
    @(negedge clk);
    check("neg_loc_packet", nbus.loc_packet, 16'h0A03);
    check("neg_err_pulse_clr", nbus.err_pulse, 0);
    tick();

    // Directed forward, local hold, single drop.
    send(16'h1234);
    tick();
    lr = 1'b0;
    send(16'hAB0C);
    repeat (5) tick();
    lr = 1'b1;
    repeat (2) tick();
    send(16'h00F0);
    repeat (3) tick();

    // Saturation.
    for (int i = 0; i < 300; i++) send(mk(-int'($urandom_range(1, 8))));
    repeat (2) tick();
    @(negedge clk);
    check("sat_err_count", bus.err_count, 255);
    tick();

    // Back-pressure on the forward FIFO.
    fr = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) send(16'(i * 16'h0010));
    bus.in_valid  = 1'b1;
    bus.in_packet = 16'h0050;
    @(negedge clk);
    check("bp_in_ready", bus.in_ready, 0);
    repeat (3) tick();
    fr = 1'b1;
    send(16'h0050);
    repeat (6) tick();

    // Random traffic.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] p;
      case ($urandom_range(0, 3))
        0:       p = mk(0);
        1, 2:    p = mk(int'($urandom_range(1, 7)));
        default: p = 16'($urandom());
      endcase
      send(p);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    rnd_rdy = 1'b0;
    fr = 1'b1;
    lr = 1'b1;
    repeat (12) tick();

    // Reset with queued entries.
    fr = 1'b0;
    tick();
    send(16'h0010);
    send(16'h0020);
    send(16'h0030);
    #1;
    rst_n = 1'b0;
    fq.delete();
    lq.delete();
    exp_cnt   = 0;
    exp_pulse = 1'b0;
    #1;
    check("mid_rst_fwd_valid", bus.fwd_valid, 0);
    check("mid_rst_err_count", bus.err_count, 0);
    check("mid_rst_in_ready",  bus.in_ready,  1);
    rst_n = 1'b1;
    fr = 1'b1;
    tick();
    send(16'h0070);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fwd_stage_buf.md
# fwd_stage_buf

Parametrised, buffered single-axis forwarding stage for the mesh router. Each accepted packet has its signed hop-offset field examined: packets with hops left toward the configured direction get the offset stepped one hop toward zero and are queued on the forward output. Packets at offset zero are queued unchanged on the local output. Wrong-sign packets are dropped and counted. It replaces the combinational east forwarder: the hop direction is a parameter, and the block adds valid/ready back-pressure, per-output FIFOs and error accounting.

## Interface
- PKT_W, 16, packet width in bits
- OFF_LSB, 4, bit position of the offset field LSB inside the packet
- OFF_W, 4, offset field width; two's complement
- DIR_POS, 1, 1: forward while offset > 0 and decrement; 0: forward while offset < 0 and increment
- FIFO_DEPTH, 4, entries per output FIFO; power of two, ≥ 2
- CNT_W, 8, error counter width

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input packet valid
- in_ready  out  1  stage can accept this cycle
- in_packet  in  PKT_W  input packet
- fwd_valid  out  1  forward FIFO non-empty
- fwd_ready  in  1  downstream hop accepts
- fwd_packet  out  PKT_W  forward FIFO head
- loc_valid  out  1  local FIFO non-empty
- loc_ready  in  1  local sink accepts
- loc_packet  out  PKT_W  local FIFO head
- err_pulse  out  1  one-cycle pulse per dropped packet
- err_count  out  CNT_W  saturating count of dropped packets

## Operation
- Handshake: a transfer occurs on a rising edge where valid && ready. Producers hold valid and data stable until the transfer.
- in_ready is 1 only when neither FIFO is full. This rule is conservative and independent of in_packet. A pop in the same cycle does not free a slot for that cycle's push.
- Classification of an accepted packet, with off = in_packet[OFF_LSB+OFF_W-1:OFF_LSB], signed:
  - off == 0: push in_packet unchanged into the local FIFO.
  - DIR_POS=1 and off > 0, or DIR_POS=0 and off < 0: push into the forward FIFO with the field replaced by off−1 (DIR_POS=1) or off+1 (DIR_POS=0). Arithmetic is OFF_W-bit; no overflow is possible in these ranges. All other bits are unchanged.
  - Otherwise: drop the packet. On the next edge, err_pulse=1 and err_count increments, saturating at 2^CNT_W−1.
- FIFOs:
  - Each FIFO is first-word-fall-through, with registered storage, read/write pointers and an occupancy count.
  - Full is count == FIFO_DEPTH. Empty is count == 0.
  - A simultaneous push and pop on one FIFO leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Output ordering: each output preserves acceptance order. Forward and local outputs are independent; a stall on one does not reorder the other.
- No $display and no other simulation-only constructs.

## Timing
- Reset (rst_n low, asynchronous):
  - FIFOs emptied and pointers zeroed.
  - fwd_valid=0, loc_valid=0, fwd_packet=0, loc_packet=0.
  - err_pulse=0, err_count=0.
  - in_ready=1 combinationally once reset is held.
- Reset mid-operation discards all queued packets; nothing partially transferred survives.
- Latency: a packet accepted at edge k appears on its output with valid=1 in the cycle after edge k, i.e. 1 cycle.
- Throughput: 1 packet per cycle while no FIFO is full and the outputs are drained.
- err_pulse is registered: high for exactly the cycle after each dropping edge. Back-to-back drops give a continuous high and one increment per packet.
- Head data (fwd_packet, loc_packet) changes only on a pop or on a push into an empty FIFO.

## Test plan
- Forward, DIR_POS=1, defaults: in_packet=16'h1234 (off=3) accepted, fwd_ready=1 → next cycle fwd_valid=1, fwd_packet=16'h1224, loc_valid=0, err_pulse=0.
- Local: in_packet=16'hAB0C (off=0) → next cycle loc_valid=1, loc_packet=16'hAB0C. With loc_ready=0 the packet is held until loc_ready=1, then loc_valid=0.
- Illegal and saturation, DIR_POS=1, CNT_W=8:
  - in_packet=16'h00F0 (off=−1) → no FIFO push, err_pulse=1 for one cycle, err_count=1.
  - 300 consecutive illegal packets → err_count=255.
- Back-pressure: fwd_ready=0, stream of forwardable packets 16'h0010,16'h0020,… →
  - in_ready=0 after 4 accepts.
  - Raising fwd_ready drains 16'h0000,16'h0010,16'h0020,16'h0030 in order.
  - in_ready returns to 1 the cycle after the first pop.
- DIR_POS=0 instance: 16'h00E0 (off=−2) → fwd_packet=16'h00F0. 16'h0020 → dropped, err_pulse=1.
- Reset mid-stream: with 3 entries queued, pulse rst_n low between edges → immediately fwd_valid=0, err_count=0, in_ready=1. The first packet after release emerges 1 cycle after acceptance.
